alu_sched: RTL and testbench

- Sequencer/arbiter that shares one 64-bit Y86-64 ALU (add/sub/and/xor, 2-bit function code, 3-bit CC {ZF,SF,OF}) between two requesters.
- Example requesters: the execute path (port 0) and an auxiliary address/stack-pointer adder (port 1).
- Round-robin arbitration; registers operands into the ALU and captures valE.
- Owns the architectural condition-code register, updated only for requests flagged set_cc.

---
 rtl/alu_sched_if.sv | 33 +++
 rtl/alu_sched.sv | 75 +++++++
 tb/tb_alu_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_sched_if.sv
// alu_sched_if: requester, ALU and response signals of the shared-ALU sequencer.
interface alu_sched_if #(parameter int WIDTH = 64);
  logic             req0_valid, req0_ready, req0_setcc;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [1:0]       req0_fun;
  logic             req1_valid, req1_ready, req1_setcc;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [1:0]       req1_fun;
  logic [WIDTH-1:0] alu_a, alu_b, alu_vale;
  logic [1:0]       alu_fun;
  logic [2:0]       alu_cc;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_vale;
  logic [2:0]       cc_q;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fun, req0_setcc,
    input  req1_valid, req1_a, req1_b, req1_fun, req1_setcc,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_fun,
    input  alu_vale, alu_cc,
    output rsp_valid, rsp_id, rsp_vale, cc_q,
    input  rsp_ready
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_fun, req0_setcc,
    output req1_valid, req1_a, req1_b, req1_fun, req1_setcc,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_fun,
    output alu_vale, alu_cc,
    input  rsp_valid, rsp_id, rsp_vale, cc_q,
    output rsp_ready
  );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: round-robin sharing of one Y86-64 ALU between two requesters, owns the CC register.
// Define ALU_SCHED_FIXED_PRIO_EN to make port 0 win every tie instead of alternating.
module alu_sched #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input logic       clk,
  input logic       rst,
  alu_sched_if.slave io
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, vale_q;
  logic [1:0]       fun_q;
  logic             setcc_q, id_q, rsp_id_q;
  logic [2:0]       cc_r;
  logic             any, gid, accept;
`ifndef ALU_SCHED_FIXED_PRIO_EN
  logic             last_grant;
`endif
  always_comb begin
    any = io.req0_valid | io.req1_valid;
`ifdef ALU_SCHED_FIXED_PRIO_EN
    gid = !io.req0_valid;
`else
    gid = (io.req0_valid & io.req1_valid) ? !last_grant : io.req1_valid;
`endif
    accept = (state_q == IDLE) && any;
    state_d = state_q;
    state_d = state_q == IDLE ? (any ? EXEC : IDLE) :
              state_q == EXEC ? RESP : (io.rsp_ready ? IDLE : RESP);
  end
  assign io.req0_ready = accept & !gid;
  assign io.req1_ready = accept & gid;
  assign io.alu_a      = a_q;
  assign io.alu_b      = b_q;
  assign io.alu_fun    = fun_q;
  assign io.rsp_valid  = state_q == RESP;
  assign io.rsp_id     = rsp_id_q;
  assign io.rsp_vale   = vale_q;
  assign io.cc_q       = cc_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      fun_q    <= '0;
      setcc_q  <= 1'b0;
      id_q     <= 1'b0;
      rsp_id_q <= 1'b0;
      vale_q   <= '0;
      cc_r     <= CC_RESET;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= gid ? io.req1_a : io.req0_a;
        b_q     <= gid ? io.req1_b : io.req0_b;
        fun_q   <= gid ? io.req1_fun : io.req0_fun;
        setcc_q <= gid ? io.req1_setcc : io.req0_setcc;
        id_q    <= gid;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        last_grant <= gid;
`endif
      end
      if (state_q == EXEC) begin
        vale_q   <= io.alu_vale;
        rsp_id_q <= id_q;
        if (setcc_q) cc_r <= io.alu_cc;
      end
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed vectors with a transaction-level model checked every cycle.
module tb_alu_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_sched_if #(.WIDTH(64)) io();
  alu_sched #(.WIDTH(64), .CC_RESET(3'b100)) dut (.clk(clk), .rst(rst), .io(io));
  int checks = 0;
  int errors = 0;
  function automatic logic [66:0] alu_f(logic [63:0] a, logic [63:0] b, logic [1:0] fun);
    logic [63:0] r;
    logic of;
    r = fun == 2'd0 ? b + a : fun == 2'd1 ? b - a : fun == 2'd2 ? (b & a) : (b ^ a);
    of = fun == 2'd0 ? (a[63] == b[63] && r[63] != a[63]) :
         fun == 2'd1 ? (a[63] != b[63] && r[63] != b[63]) : 1'b0;
    return {r == 64'd0, r[63], of, r};
  endfunction
  assign {io.alu_cc, io.alu_vale} = alu_f(io.alu_a, io.alu_b, io.alu_fun);
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  typedef struct packed {logic [63:0] a, b; logic [1:0] fun; logic setcc, id;} op_t;
  int         phase = 0;
  op_t        pend;
  logic       m_last;
  logic [2:0] m_cc;
  logic [63:0] m_vale;
  logic       m_id;
  bit         armed = 0;
  function automatic logic m_gid();
`ifdef ALU_SCHED_FIXED_PRIO_EN
    return !io.req0_valid;
`else
    return (io.req0_valid && io.req1_valid) ? !m_last : io.req1_valid;
`endif
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      phase <= 0; pend <= '0; m_last <= 1'b1; m_cc <= 3'b100; m_vale <= '0; m_id <= 1'b0; armed <= 1'b1;
    end else if (phase == 0) begin
      if (io.req0_valid || io.req1_valid) begin
        pend <= m_gid() ? {io.req1_a, io.req1_b, io.req1_fun, io.req1_setcc, 1'b1}
                        : {io.req0_a, io.req0_b, io.req0_fun, io.req0_setcc, 1'b0};
        m_last <= m_gid();
        phase <= 1;
      end
    end else if (phase == 1) begin
      m_vale <= alu_f(pend.a, pend.b, pend.fun)[63:0];
      if (pend.setcc) m_cc <= alu_f(pend.a, pend.b, pend.fun)[66:64];
      m_id <= pend.id;
      phase <= 2;
    end else if (io.rsp_ready) phase <= 0;
  end
  always @(negedge clk) if (armed) begin
    chk("req0_ready", io.req0_ready, phase == 0 && (io.req0_valid || io.req1_valid) && !m_gid());
    chk("req1_ready", io.req1_ready, phase == 0 && (io.req0_valid || io.req1_valid) && m_gid());
    chk("rsp_valid", io.rsp_valid, phase == 2);
    chk("rsp_vale", io.rsp_vale, m_vale);
    chk("rsp_id", io.rsp_id, m_id);
    chk("cc_q", io.cc_q, m_cc);
    chk("alu_a", io.alu_a, pend.a);
    chk("alu_b", io.alu_b, pend.b);
    chk("alu_fun", io.alu_fun, pend.fun);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(bit p, logic [63:0] a, logic [63:0] b, logic [1:0] fun, bit setcc);
    if (p) {io.req1_a, io.req1_b, io.req1_fun, io.req1_setcc, io.req1_valid} = {a, b, fun, setcc, 1'b1};
    else   {io.req0_a, io.req0_b, io.req0_fun, io.req0_setcc, io.req0_valid} = {a, b, fun, setcc, 1'b1};
    #1;
    chk("accept_ready", p ? io.req1_ready : io.req0_ready, 1);
    tick();
    io.req0_valid = 1'b0;
    io.req1_valid = 1'b0;
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  logic exp_grant [4];
  initial begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    {io.req0_valid, io.req0_a, io.req0_b, io.req0_fun, io.req0_setcc} = '0;
    {io.req1_valid, io.req1_a, io.req1_b, io.req1_fun, io.req1_setcc} = '0;
    io.rsp_ready = 1'b1;
    repeat (2) tick();
    chk("reset_rsp_valid", io.rsp_valid, 0);
    chk("reset_cc", io.cc_q, 3'b100);
    chk("reset_vale", io.rsp_vale, 0);
    chk("reset_alu_a", io.alu_a, 0);
    rst = 1'b0;
    tick();
    issue(0, 64'd5, 64'd7, 2'd0, 1);
    chk("add_valid", io.rsp_valid, 1);
    chk("add_vale", io.rsp_vale, 64'd12);
    chk("add_id", io.rsp_id, 0);
    chk("add_cc", io.cc_q, 3'b000);
    tick();
    issue(1, 64'd9, 64'd9, 2'd1, 1);
    chk("sub_vale", io.rsp_vale, 64'd0);
    chk("sub_id", io.rsp_id, 1);
    chk("sub_cc", io.cc_q, 3'b100);
    tick();
    issue(0, 64'd3, 64'd5, 2'd3, 0);
    chk("xor_vale", io.rsp_vale, 64'd6);
    chk("xor_cc_kept", io.cc_q, 3'b100);
    tick();
    issue(1, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 2'd0, 1);
    chk("ovf_vale", io.rsp_vale, 64'h8000_0000_0000_0000);
    chk("ovf_cc", io.cc_q, 3'b011);
    tick();
    {io.req0_a, io.req0_b, io.req0_fun, io.req0_setcc, io.req0_valid} = {64'd1, 64'd2, 2'd0, 1'b0, 1'b1};
    {io.req1_a, io.req1_b, io.req1_fun, io.req1_setcc, io.req1_valid} = {64'd1, 64'd10, 2'd0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      while (!io.rsp_valid && n < 20) begin tick(); n++; end
      chk("contention_wait", n < 20, 1);
      chk("contention_grant", io.rsp_id, exp_grant[k]);
      chk("contention_vale", io.rsp_vale, exp_grant[k] ? 64'd11 : 64'd3);
      if (k == 3) begin io.req0_valid = 1'b0; io.req1_valid = 1'b0; end
      tick();
    end
    tick();
    io.rsp_ready = 1'b0;
    issue(0, 64'd4, 64'd4, 2'd2, 0);
    {io.req1_a, io.req1_b, io.req1_fun, io.req1_setcc, io.req1_valid} = {64'd2, 64'd3, 2'd0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", io.rsp_valid, 1);
      chk("bp_vale", io.rsp_vale, 64'd4);
      chk("bp_ready1", io.req1_ready, 0);
      tick();
    end
    io.rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_next_accept", io.req1_ready, 1);
    tick();
    io.req1_valid = 1'b0;
    tick();
    chk("bp_next_vale", io.rsp_vale, 64'd5);
    chk("bp_next_id", io.rsp_id, 1);
    tick();
    {io.req0_a, io.req0_b, io.req0_fun, io.req0_setcc, io.req0_valid} = {64'd5, 64'd2, 2'd1, 1'b1, 1'b1};
    tick();
    io.req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstexec_valid", io.rsp_valid, 0);
    chk("rstexec_cc", io.cc_q, 3'b100);
    tick();
    chk("rstexec_valid2", io.rsp_valid, 0);
    chk("rstexec_cc2", io.cc_q, 3'b100);
    issue(1, 64'd2, 64'd3, 2'd0, 1);
    chk("post_rst_vale", io.rsp_vale, 64'd5);
    chk("post_rst_cc", io.cc_q, 3'b000);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
